// File: rtl/hmmm_host_loader.sv
// hmmm_host_loader: program loader and io bridge for the HMMM CPU; status flags built only with HMMM_HOST_LOADER_STATUS_EN
module hmmm_host_loader #(
    parameter int BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        load_last,
    input  logic        restart,
    output logic        cpu_pgrm_addr,
    output logic        cpu_pgrm_data,
    output logic        cpu_rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic        cpu_halt,
    output logic [15:0] io_out,
    output logic        io_oe,
    input  logic [15:0] io_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  status
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BOOT, RUN, HALTED} state_t;
    state_t state, state_nxt;
    logic [7:0]  addr;
    logic [15:0] word, buf_data, boot_cnt;
    logic        last_q, buf_full, read_q, write_q;
    logic        rd, wr, rd_fall, wr_rise, accept, boot_done;

    assign rd        = cpu_read && state == RUN;
    assign wr        = cpu_write && state == RUN;
    assign rd_fall   = read_q && !rd;
    assign wr_rise   = wr && !write_q;
    assign accept    = state == IDLE && load_valid;
    assign boot_done = boot_cnt == 16'(BOOT_CYCLES - 1);
    assign in_ready  = !buf_full && !rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        load_ready    = 1'b0;
        cpu_pgrm_addr = 1'b0;
        cpu_pgrm_data = 1'b0;
        cpu_rst       = 1'b0;
        io_oe         = 1'b0;
        io_out        = 16'h0000;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                state_nxt  = load_valid ? ADDR : IDLE;
            end
            ADDR: begin
                cpu_pgrm_addr = 1'b1;
                io_oe         = 1'b1;
                io_out        = {8'h00, addr};
                state_nxt     = DATA;
            end
            DATA: begin
                cpu_pgrm_data = 1'b1;
                io_oe         = 1'b1;
                io_out        = word;
                state_nxt     = last_q ? BOOT : IDLE;
            end
            BOOT: begin
                cpu_rst   = 1'b1;
                state_nxt = boot_done ? RUN : BOOT;
            end
            RUN: begin
                io_oe     = cpu_read;
                io_out    = cpu_read && buf_full ? buf_data : 16'h0000;
                state_nxt = cpu_halt ? HALTED : RUN;
            end
            HALTED:  state_nxt = restart ? IDLE : HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= 8'h00;
            word      <= 16'h0000;
            last_q    <= 1'b0;
            boot_cnt  <= 16'h0000;
            buf_full  <= 1'b0;
            buf_data  <= 16'h0000;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            read_q  <= rd;
            write_q <= wr;
            if (accept) begin
                word   <= load_data;
                last_q <= load_last;
            end
            if (state == DATA) addr <= addr + 8'd1;
            if (state == BOOT) begin
                addr     <= 8'h00;
                boot_cnt <= boot_done ? 16'h0000 : boot_cnt + 16'd1;
            end
            if (in_valid && in_ready) begin
                buf_full <= 1'b1;
                buf_data <= in_data;
            end else if (rd_fall) begin
                buf_full <= 1'b0;
            end
            if (wr_rise && (!out_valid || out_ready)) begin
                out_data  <= io_in;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef HMMM_HOST_LOADER_STATUS_EN
    logic [2:0] flags;
    logic       rd_rise;
    assign rd_rise = rd && !read_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          flags <= 3'b000;
        else if (state == HALTED && restart) flags <= 3'b000;
        else flags <= flags | {wr_rise && out_valid && !out_ready,
                               rd_rise && !buf_full,
                               accept && addr == 8'hFF && !load_last};
    end
    assign status = flags;
`else
    assign status = 3'b000;
`endif
endmodule

// File: tb/tb_hmmm_host_loader.sv
// tb_hmmm_host_loader: directed + randomized bench with a queue-based reference model of hmmm_host_loader
module tb_hmmm_host_loader;
    localparam int BC = 2;
    logic        clk = 1'b0, rst;
    logic        load_valid, load_ready, load_last, restart;
    logic [15:0] load_data;
    logic        cpu_pgrm_addr, cpu_pgrm_data, cpu_rst, cpu_read, cpu_write, cpu_halt;
    logic [15:0] io_out, io_in, in_data, out_data;
    logic        io_oe, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  status;

    int          checks = 0, errors = 0;
    int          loaded;
    logic        wrap_f, uflow_f, oflow_f;
    logic [15:0] exp_buf[$];
    logic [15:0] exp_out[$];
    logic [15:0] prog[$];

    hmmm_host_loader #(.BOOT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .restart(restart),
        .cpu_pgrm_addr(cpu_pgrm_addr), .cpu_pgrm_data(cpu_pgrm_data), .cpu_rst(cpu_rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_halt(cpu_halt),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .status(status)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
`ifdef HMMM_HOST_LOADER_STATUS_EN
        return {13'd0, oflow_f, uflow_f, wrap_f};
`else
        return {13'd0, {oflow_f, uflow_f, wrap_f} & 3'b000};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        wrap_f = 1'b0;
        uflow_f = 1'b0;
        oflow_f = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w, input logic last);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            chk("idle_ready", {15'd0, load_ready}, 16'd1);
            chk("idle_quiet", {13'd0, cpu_pgrm_addr, cpu_pgrm_data, io_oe}, 16'd0);
            step();
        end
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        #1 chk("load_ready", {15'd0, load_ready}, 16'd1);
        if (loaded % 256 == 255 && !last) wrap_f = 1'b1;
        step();
        load_valid = 1'b0;
        load_data  = 16'($urandom);
        load_last  = 1'($urandom);
        #1;
        chk("addr_strobe", {14'd0, cpu_pgrm_addr, cpu_pgrm_data}, 16'd2);
        chk("addr_oe", {15'd0, io_oe}, 16'd1);
        chk("addr_io", io_out, 16'(loaded % 256));
        chk("addr_busy", {15'd0, load_ready}, 16'd0);
        step();
        chk("data_strobe", {14'd0, cpu_pgrm_addr, cpu_pgrm_data}, 16'd1);
        chk("data_oe", {15'd0, io_oe}, 16'd1);
        chk("data_io", io_out, w);
        chk("data_busy", {15'd0, load_ready}, 16'd0);
        loaded++;
        step();
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) load_word(prog[i], i == prog.size() - 1);
        for (int b = 0; b < BC; b++) begin
            chk("boot_rst", {15'd0, cpu_rst}, 16'd1);
            chk("boot_busy", {15'd0, load_ready}, 16'd0);
            step();
        end
        loaded = 0;
        chk("run_rst", {15'd0, cpu_rst}, 16'd0);
        chk("run_busy", {15'd0, load_ready}, 16'd0);
        chk("load_status", {13'd0, status}, exp_status());
    endtask

    task automatic preload(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        #1 chk("pre_ready", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        exp_buf.push_back(v);
        #1 chk("pre_full", {15'd0, in_ready}, 16'd0);
    endtask

    task automatic read_pulse(input int len);
        logic [15:0] e;
        e = exp_buf.size() != 0 ? exp_buf[0] : 16'h0000;
        if (exp_buf.size() == 0) uflow_f = 1'b1;
        cpu_read = 1'b1;
        for (int k = 0; k < len; k++) begin
            #1;
            chk("rd_oe", {15'd0, io_oe}, 16'd1);
            chk("rd_data", io_out, e);
            chk("rd_inready", {15'd0, in_ready}, 16'd0);
            step();
        end
        cpu_read = 1'b0;
        #1;
        chk("rd_fall_oe", {15'd0, io_oe}, 16'd0);
        chk("rd_fall_ready", {15'd0, in_ready}, {15'd0, exp_buf.size() == 0});
        step();
        exp_buf.delete();
        chk("rd_after_ready", {15'd0, in_ready}, 16'd1);
        chk("rd_status", {13'd0, status}, exp_status());
    endtask

    task automatic write_pulse(input logic [15:0] v, input logic rdy);
        cpu_write = 1'b1;
        io_in     = v;
        out_ready = rdy;
        if (exp_out.size() == 0 || rdy) begin
            exp_out.delete();
            exp_out.push_back(v);
        end else begin
            oflow_f = 1'b1;
        end
        step();
        cpu_write = 1'b0;
        out_ready = 1'b0;
        io_in     = 16'($urandom);
        #1;
        chk("wr_valid", {15'd0, out_valid}, 16'd1);
        chk("wr_data", out_data, exp_out[0]);
        chk("wr_status", {13'd0, status}, exp_status());
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        #1 chk("drain_valid", {15'd0, out_valid}, {15'd0, exp_out.size() != 0});
        step();
        out_ready = 1'b0;
        exp_out.delete();
        #1 chk("drain_empty", {15'd0, out_valid}, 16'd0);
    endtask

    task automatic halt_restart();
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        #1 chk("halted_busy", {15'd0, load_ready}, 16'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        clear_flags();
        #1;
        chk("restart_idle", {15'd0, load_ready}, 16'd1);
        chk("restart_status", {13'd0, status}, exp_status());
    endtask

    initial begin
        logic [15:0] v1, v2;
        rst = 1'b0;
        {load_valid, load_last, restart, cpu_read, cpu_write, cpu_halt, in_valid, out_ready} = '0;
        load_data = '0;
        io_in = '0;
        in_data = '0;
        loaded = 0;
        clear_flags();
        #12;
        chk("rst_ready", {15'd0, load_ready}, 16'd1);
        chk("rst_strobes", {13'd0, cpu_pgrm_addr, cpu_pgrm_data, cpu_rst}, 16'd0);
        chk("rst_io", {15'd0, io_oe}, 16'd0);
        chk("rst_io_out", io_out, 16'd0);
        chk("rst_out", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_status", {13'd0, status}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clk) rst = 1'b1;
        step();

        prog = {16'h1234, 16'h5678, 16'h0000};
        load_prog();

        preload(16'hBEEF);
        read_pulse(2);
        repeat (4) begin
            if ($urandom_range(0, 3) != 0) preload(16'($urandom));
            read_pulse($urandom_range(1, 3));
        end

        write_pulse(16'h00AA, 1'b0);
        write_pulse(16'h00BB, 1'b0);
        chk("ovf_keep", out_data, 16'h00AA);
        drain();
        repeat (4) write_pulse(16'($urandom), 1'($urandom));
        drain();
        write_pulse(16'($urandom), 1'b0);
        write_pulse(16'($urandom), 1'b1);
        drain();

        v1 = 16'($urandom);
        v2 = 16'($urandom);
        cpu_write = 1'b1;
        io_in = v1;
        exp_out.push_back(v1);
        step();
        io_in = v2;
        #1 chk("hold_first", out_data, v1);
        step();
        cpu_write = 1'b0;
        #1;
        chk("hold_data", out_data, v1);
        chk("hold_status", {13'd0, status}, exp_status());
        drain();

        v1 = 16'($urandom);
        v2 = 16'($urandom);
        preload(v1);
        cpu_read = 1'b1;
        cpu_write = 1'b1;
        io_in = v2;
        exp_out.push_back(v2);
        #1;
        chk("both_oe", {15'd0, io_oe}, 16'd1);
        chk("both_io", io_out, v1);
        step();
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        #1;
        chk("both_wr_valid", {15'd0, out_valid}, 16'd1);
        chk("both_wr_data", out_data, v2);
        step();
        exp_buf.delete();
        chk("both_rd_done", {15'd0, in_ready}, 16'd1);
        drain();

        restart = 1'b1;
        step();
        restart = 1'b0;
        #1 chk("run_restart_ignored", {15'd0, load_ready}, 16'd0);

        read_pulse(1);
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        cpu_read = 1'b1;
        cpu_write = 1'b1;
        io_in = 16'($urandom);
        #1;
        chk("halt_rd_oe", {15'd0, io_oe}, 16'd0);
        chk("halt_rd_ready", {15'd0, in_ready}, 16'd1);
        step();
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        #1;
        chk("halt_wr_ignored", {15'd0, out_valid}, 16'd0);
        chk("halt_status", {13'd0, status}, exp_status());
        restart = 1'b1;
        step();
        restart = 1'b0;
        clear_flags();
        #1;
        chk("restart_idle", {15'd0, load_ready}, 16'd1);
        chk("restart_status", {13'd0, status}, exp_status());

        prog.delete();
        repeat (257) prog.push_back(16'($urandom));
        load_prog();
        write_pulse(16'($urandom), 1'b0);
        halt_restart();

        prog.delete();
        repeat ($urandom_range(1, 6)) prog.push_back(16'($urandom));
        load_prog();
        halt_restart();

        preload(16'($urandom));
        load_word(16'($urandom), 1'b0);
        load_valid = 1'b1;
        load_data = 16'($urandom);
        load_last = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        #1 chk("pre_rst_data", {15'd0, cpu_pgrm_data}, 16'd1);
        rst = 1'b0;
        #1;
        chk("arst_strobes", {13'd0, cpu_pgrm_addr, cpu_pgrm_data, cpu_rst}, 16'd0);
        chk("arst_oe", {15'd0, io_oe}, 16'd0);
        chk("arst_io", io_out, 16'd0);
        chk("arst_ready", {15'd0, load_ready}, 16'd1);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("arst_out", {15'd0, out_valid}, 16'd0);
        chk("arst_out_data", out_data, 16'd0);
        chk("arst_status", {13'd0, status}, 16'd0);
        clear_flags();
        exp_buf.delete();
        exp_out.delete();
        loaded = 0;
        @(negedge clk) rst = 1'b1;
        step();
        prog = {16'($urandom)};
        load_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hmmm_host_loader.md
HMMM_HOST_LOADER -- requirements
Module: hmmm_host_loader

Interface
REQ-001 Parameter BOOT_CYCLES, default 2: number of cycles cpu_rst is held high after a program load.
REQ-002 clk  input  1  single clock for all state; rising-edge triggered.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 load_valid/load_ready/load_data[15:0]/load_last  in/out/in/in  1/1/16/1  program word stream; a word transfers when valid and ready are both high; last marks the final word.
REQ-005 restart  input  1  in HALTED, returns the block to IDLE for a new load.
REQ-006 cpu_pgrm_addr, cpu_pgrm_data  output  1  program-address and program-data strobes to the CPU.
REQ-007 cpu_rst  output  1  active-high CPU reset.
REQ-008 cpu_read, cpu_write, cpu_halt  input  1  CPU in-request, out-request and halted indications.
REQ-009 io_out[15:0], io_oe, io_in[15:0]  out/out/in  16/1/16  split CPU io bus; io_out is meaningful only when io_oe=1.
REQ-010 in_valid/in_ready/in_data[15:0]  in/out/in  host-to-CPU input words.
REQ-011 out_valid/out_ready/out_data[15:0]  out/in/out  CPU-to-host output words.
REQ-012 status[2:0]  output  3  sticky flags: [0] load_wrap, [1] read_underflow, [2] write_overflow.

Function
REQ-013 States SHALL be IDLE, ADDR, DATA, BOOT, RUN, HALTED.
REQ-014 IDLE SHALL assert load_ready; an accepted word is latched with the 8-bit address counter, and the state moves to ADDR.
REQ-015 ADDR SHALL drive cpu_pgrm_addr=1, io_oe=1 and io_out={8'h00,addr} for exactly one cycle, then move to DATA.
REQ-016 DATA SHALL drive cpu_pgrm_data=1, io_oe=1 and io_out=word for exactly one cycle, then increment addr; it moves to BOOT if the word had load_last set, otherwise to IDLE.
REQ-017 load_ready SHALL be low in every state except IDLE; the throughput is one word per 3 cycles.
REQ-018 The address counter SHALL wrap from 255 to 0; when a word is accepted at addr=255 without load_last, status[0] is set.
REQ-019 BOOT SHALL hold cpu_rst=1 for BOOT_CYCLES cycles, clear addr, and then move to RUN; cpu_rst is 0 in all other states.
REQ-020 In RUN, cpu_halt=1 SHALL move the state to HALTED; in HALTED, restart=1 moves it to IDLE, and restart is ignored in all other states.
REQ-021 Input buffer: a single entry; in_ready = ~full & ~cpu_read; the buffer fills on in_valid&in_ready.
REQ-022 While cpu_read=1 in RUN, the block SHALL drive io_oe=1 and io_out=buffer, or 16'h0000 if the buffer is empty.
REQ-023 The buffer entry SHALL be consumed at the cycle after cpu_read falls (registered falling-edge detect).
REQ-024 A cpu_read assertion that begins while the buffer is empty SHALL set status[1].
REQ-025 On the first cycle of a cpu_write assertion in RUN (rising-edge detect), io_in SHALL be captured into out_data and out_valid set next cycle.
REQ-026 out_valid SHALL clear on out_ready&out_valid.
REQ-027 If out_valid=1 at a cpu_write rising edge and out_ready=0 in that cycle, the new word SHALL be dropped, the old word kept, and status[2] set.
REQ-028 If out_valid=1 at a cpu_write rising edge and out_ready=1 in the same cycle, the new word SHALL be captured with no overflow.
REQ-029 cpu_read and cpu_write SHALL be ignored outside RUN.
REQ-030 If cpu_read and cpu_write are both high, cpu_read SHALL take priority for io_oe; the write capture still occurs.
REQ-031 Sticky status bits SHALL clear only on reset or on the IDLE entry caused by restart.

Reset
REQ-032 rst low SHALL force IDLE immediately: addr=0, buffer empty, out_valid=0, status=0, cpu_rst=0, strobes=0, io_oe=0, io_out=0, out_data=0, edge-detect registers=0.
REQ-033 Reset mid-load or mid-run SHALL abandon the operation; no partial strobe may extend past reset assertion.

Configuration
REQ-034 Macro HMMM_HOST_LOADER_STATUS_EN: when defined, status SHALL behave per REQ-012 and REQ-018/024/027/031.
REQ-035 When HMMM_HOST_LOADER_STATUS_EN is undefined, status SHALL be tied to 3'b000 and no flag registers are built; all other behaviour is unchanged.

Verification
REQ-036 Load 3 words 16'h1234, 16'h5678, 16'h0000 (last=1) -> pgrm_addr pulses with io 0x0000, 0x0001, 0x0002, each followed by pgrm_data with the word; then cpu_rst high for 2 cycles; then RUN.
REQ-037 Load 257 words, last on the final word -> status[0]=1; the 257th word is presented at address 0x00.
REQ-038 RUN, in_data=16'hBEEF preloaded, cpu_read pulsed for 2 cycles -> io_out=16'hBEEF and io_oe=1 for both cycles; in_ready=1 one cycle after cpu_read falls.
REQ-039 RUN, cpu_write with io_in=16'h00AA, then a second cpu_write with io_in=16'h00BB while out_ready=0 -> out_data stays 16'h00AA and status[2]=1.
REQ-040 RUN, cpu_read with the input buffer empty -> io_out=16'h0000 and status[1]=1; then cpu_halt=1 -> HALTED; restart=1 -> IDLE with status=0.
REQ-041 rst pulsed low during DATA -> strobes drop asynchronously and the block is in IDLE with all outputs at their reset values.
